// File: rtl/stream_pkg.sv
// Shared definitions for the simulated-ethernet stream checker.
//   DATA_W / ADDR_W : payload and destination address widths
//   LFSR_TAPS       : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   fsm_t           : framing state of the checker
package stream_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;

    // Bit n-1 of the mask corresponds to tap n.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        WAIT_SOP,
        IN_PKT
    } fsm_t;

endpackage

// File: rtl/stream_checker_if.sv
// Stream bus between the sequential-value sender and the checker.
//   data  : 64-bit payload
//   valid : beat present (sender)
//   ready : beat may be taken (receiver)
//   sop   : first beat of a packet
//   eop   : last beat of a packet
//   addr  : destination address
// Modports: tx (sender side), rx (receiver side).
interface t_DATA_STREAM;
    import stream_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [ADDR_W-1:0] addr;

    modport tx (output data, valid, sop, eop, addr, input ready);
    modport rx (input data, valid, sop, eop, addr, output ready);

endinterface

// File: rtl/stream_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used to throttle the receiver's ready.
//   clk, reset : clock, asynchronous active-high reset (loads seed)
//   enable     : advance one step per cycle when high
//   seed       : reset value, must be nonzero
//   out        : current LFSR state
module lfsr16
    import stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= seed;
        end else if (enable) begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/stream_checker.sv
// Terminating checker for the sequential-value stream.
//   clk, reset         : clock, asynchronous active-high reset
//   my_addr            : expected destination address
//   throttle_en        : enable pseudo-random deassertion of rx.ready
//   clear_stats        : synchronous pulse clearing counters and error capture
//   rx                 : incoming stream (ready driven here)
//   *_count            : saturating statistics counters
//   err_sticky         : any error seen since reset/clear
//   first_err_expected : expected payload at the first sequence error
//   first_err_got      : received payload at the first sequence error
module stream_checker
    import stream_pkg::*;
#(
    parameter int          PKT_BEATS = 4,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] my_addr,
    input  logic              throttle_en,
    input  logic              clear_stats,
    t_DATA_STREAM.rx          rx,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  seq_err_count,
    output logic [CNT_W-1:0]  frame_err_count,
    output logic [CNT_W-1:0]  addr_err_count,
    output logic              err_sticky,
    output logic [DATA_W-1:0] first_err_expected,
    output logic [DATA_W-1:0] first_err_got
);

    localparam int               IDX_W    = $clog2(PKT_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);

    logic [15:0]       lfsr;
    logic [DATA_W-1:0] expected;
    fsm_t              state;
    logic [IDX_W-1:0]  beat_idx;
    logic              accept;
    logic              seq_err;
    logic              addr_err;
    logic              frame_err;
    logic              pkt_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .seed   (LFSR_SEED),
        .out    (lfsr)
    );

    // ready depends only on registered state, never on rx.valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx.ready <= 1'b0;
        end else begin
            rx.ready <= throttle_en ? (lfsr[1:0] != 2'b00) : 1'b1;
        end
    end

    // Per-beat event decode; at most one frame error per beat.
    always_comb begin
        accept    = rx.valid & rx.ready;
        seq_err   = accept && (rx.data != expected);
        addr_err  = accept && (rx.addr != my_addr);
        frame_err = 1'b0;
        pkt_done  = 1'b0;
        if (accept) begin
            case (state)
                WAIT_SOP: frame_err = !rx.sop || (rx.eop && PKT_BEATS != 1);
                IN_PKT: begin
                    if (rx.sop) begin
                        frame_err = 1'b1;
                    end else if (rx.eop) begin
                        if (beat_idx == LAST_IDX) pkt_done  = 1'b1;
                        else                      frame_err = 1'b1;
                    end else if (beat_idx == LAST_IDX) begin
                        frame_err = 1'b1;
                    end
                end
                default: frame_err = 1'b0;
            endcase
        end
    end

    // Framing FSM and sequence tracker; untouched by clear_stats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_SOP;
            beat_idx <= '0;
            expected <= '0;
        end else if (accept) begin
            // A mismatch resyncs to the received value.
            expected <= seq_err ? rx.data + 1'b1 : expected + 1'b1;
            case (state)
                WAIT_SOP: begin
                    if (rx.sop && !frame_err) begin
                        state    <= IN_PKT;
                        beat_idx <= IDX_W'(1);
                    end
                end
                IN_PKT: begin
                    if (rx.sop) begin
                        beat_idx <= IDX_W'(1);
                    end else if (rx.eop || beat_idx == LAST_IDX) begin
                        state    <= WAIT_SOP;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                default: state <= WAIT_SOP;
            endcase
        end
    end

    // Statistics; a same-cycle clear takes priority over beat updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count         <= '0;
            pkt_count          <= '0;
            seq_err_count      <= '0;
            frame_err_count    <= '0;
            addr_err_count     <= '0;
            err_sticky         <= 1'b0;
            first_err_expected <= '0;
            first_err_got      <= '0;
        end else if (clear_stats) begin
            beat_count         <= '0;
            pkt_count          <= '0;
            seq_err_count      <= '0;
            frame_err_count    <= '0;
            addr_err_count     <= '0;
            err_sticky         <= 1'b0;
            first_err_expected <= '0;
            first_err_got      <= '0;
        end else begin
            if (accept)    beat_count      <= sat_inc(beat_count);
            if (pkt_done)  pkt_count       <= sat_inc(pkt_count);
            if (seq_err)   seq_err_count   <= sat_inc(seq_err_count);
            if (frame_err) frame_err_count <= sat_inc(frame_err_count);
            if (addr_err)  addr_err_count  <= sat_inc(addr_err_count);
            if (seq_err || frame_err || addr_err) err_sticky <= 1'b1;
            if (seq_err && !err_sticky) begin
                first_err_expected <= expected;
                first_err_got      <= rx.data;
            end
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
module tb_stream_checker;
    import stream_pkg::*;

    localparam int PKT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  my_addr = 4'd5;
    logic        throttle_en = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count;
    logic        err_sticky;
    logic [63:0] first_err_expected, first_err_got;

    t_DATA_STREAM bus ();

    stream_checker #(
        .PKT_BEATS (PKT),
        .CNT_W     (32),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .my_addr            (my_addr),
        .throttle_en        (throttle_en),
        .clear_stats        (clear_stats),
        .rx                 (bus),
        .beat_count         (beat_count),
        .pkt_count          (pkt_count),
        .seq_err_count      (seq_err_count),
        .frame_err_count    (frame_err_count),
        .addr_err_count     (addr_err_count),
        .err_sticky         (err_sticky),
        .first_err_expected (first_err_expected),
        .first_err_got      (first_err_got)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned stalls = 0;
    int unsigned gap_max = 0;

    // Reference model: counts of what the stream rules say should have happened.
    logic [31:0] m_beats, m_pkts, m_seq, m_frame, m_addr;
    logic        m_sticky;
    logic [63:0] m_exp, m_fe, m_fg;
    int          m_pos;   // beats of the current packet already seen (0 = between packets)

    task automatic model_reset();
        m_beats = 0; m_pkts = 0; m_seq = 0; m_frame = 0; m_addr = 0;
        m_sticky = 1'b0; m_fe = '0; m_fg = '0; m_exp = '0; m_pos = 0;
    endtask

    task automatic model_clear();
        m_beats = 0; m_pkts = 0; m_seq = 0; m_frame = 0; m_addr = 0;
        m_sticky = 1'b0; m_fe = '0; m_fg = '0;
    endtask

    task automatic model_beat(input logic [63:0] d, input logic s, input logic e, input logic [3:0] a);
        logic bad_seq, bad_addr, bad_frame, last;
        m_beats++;
        bad_seq = (d != m_exp);
        if (bad_seq) begin
            m_seq++;
            if (!m_sticky) begin
                m_fe = m_exp;
                m_fg = d;
            end
        end
        // The stream is expected to continue one past whatever arrived.
        m_exp = d + 64'd1;
        bad_addr = (a != my_addr);
        if (bad_addr) m_addr++;
        bad_frame = 1'b0;
        if (m_pos == 0) begin
            if (!s || e) bad_frame = 1'b1;
            else         m_pos = 1;
        end else if (s) begin
            bad_frame = 1'b1;
            m_pos = 1;
        end else begin
            last = (m_pos == PKT - 1);
            if (e || last) begin
                if (e && last) m_pkts++;
                else           bad_frame = 1'b1;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (bad_frame) m_frame++;
        if (bad_seq || bad_addr || bad_frame) m_sticky = 1'b1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                             input logic [3:0] a, input logic clr);
        int unsigned w;
        @(negedge clk);
        bus.valid   = 1'b0;
        clear_stats = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        bus.valid   = 1'b1;
        bus.data    = d;
        bus.sop     = s;
        bus.eop     = e;
        bus.addr    = a;
        clear_stats = clr;
        w = 0;
        while (bus.ready !== 1'b1 && w < 200) begin
            stalls++;
            w++;
            @(negedge clk);
        end
        n_checks++;
        if (bus.ready !== 1'b1) begin
            $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", bus.ready, w);
        end else begin
            n_pass++;
            @(posedge clk);
            model_beat(d, s, e, a);
            if (clr) model_clear();
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid   = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send_stream(input logic [63:0] start, input int npkts, input logic [3:0] a);
        for (int p = 0; p < npkts; p++)
            for (int b = 0; b < PKT; b++)
                send_beat(start + 64'(p * PKT + b), b == 0, b == PKT - 1, a, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.valid = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.data = '0; bus.addr = '0;
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", bus.ready);
        else n_pass++;
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky,
             first_err_expected, first_err_got} !== '0)
            $display("FAIL reset_outputs: got beats=%0d pkts=%0d seq=%0d frame=%0d addr=%0d sticky=%b fe=%h fg=%h, required all 0",
                     beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky,
                     first_err_expected, first_err_got);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", bus.ready);
        else n_pass++;
    endtask

    task automatic test_clean();
        do_reset();
        throttle_en = 1'b0; gap_max = 0; stalls = 0;
        send_stream(64'd0, 10, 4'd5);
        idle();
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky}
            !== {32'd40, 32'd10, 32'd0, 32'd0, 32'd0, 1'b0})
            $display("FAIL clean_counts: got beats=%0d pkts=%0d seq=%0d frame=%0d addr=%0d sticky=%b, required 40 10 0 0 0 0",
                     beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky);
        else n_pass++;
        n_checks++;
        if (stalls !== 0) $display("FAIL clean_no_stall: got %0d stalls required 0", stalls);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        throttle_en = 1'b1; gap_max = 1; stalls = 0;
        send_stream(64'd0, 10, 4'd5);
        idle();
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky}
            !== {32'd40, 32'd10, 32'd0, 32'd0, 32'd0, 1'b0})
            $display("FAIL bp_counts: got beats=%0d pkts=%0d seq=%0d frame=%0d addr=%0d sticky=%b, required 40 10 0 0 0 0",
                     beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky);
        else n_pass++;
        n_checks++;
        if (stalls == 0) $display("FAIL bp_stalls: got 0 stalls required >0");
        else n_pass++;
        throttle_en = 1'b0; gap_max = 0;
    endtask

    task automatic test_seq_gap();
        logic [63:0] seq [12];
        logic [63:0] vals;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            vals = 64'(i < 5 ? i : i + 1);
            seq[i] = vals;
        end
        for (int i = 0; i < 12; i++)
            send_beat(seq[i], i % PKT == 0, i % PKT == PKT - 1, 4'd5, 1'b0);
        idle();
        n_checks++;
        if ({seq_err_count, first_err_expected, first_err_got} !== {32'd1, 64'd5, 64'd6})
            $display("FAIL seq_gap: got seq=%0d fe=%0d fg=%0d, required 1 5 6",
                     seq_err_count, first_err_expected, first_err_got);
        else n_pass++;
        n_checks++;
        if ({beat_count, pkt_count, frame_err_count, err_sticky} !== {m_beats, m_pkts, m_frame, m_sticky})
            $display("FAIL seq_gap_model: got beats=%0d pkts=%0d frame=%0d sticky=%b, required %0d %0d %0d %b",
                     beat_count, pkt_count, frame_err_count, err_sticky, m_beats, m_pkts, m_frame, m_sticky);
        else n_pass++;
    endtask

    task automatic test_framing();
        do_reset();
        send_beat(64'd0, 1'b1, 1'b0, 4'd5, 1'b0);
        send_beat(64'd1, 1'b0, 1'b0, 4'd5, 1'b0);
        send_beat(64'd2, 1'b0, 1'b1, 4'd5, 1'b0);
        idle();
        n_checks++;
        if ({frame_err_count, pkt_count} !== {32'd1, 32'd0})
            $display("FAIL frame_short: got frame=%0d pkts=%0d, required 1 0", frame_err_count, pkt_count);
        else n_pass++;
        send_beat(64'd3, 1'b0, 1'b0, 4'd5, 1'b0);
        send_stream(64'd4, 1, 4'd5);
        idle();
        n_checks++;
        if ({frame_err_count, pkt_count, seq_err_count} !== {32'd2, 32'd1, 32'd0})
            $display("FAIL frame_stray: got frame=%0d pkts=%0d seq=%0d, required 2 1 0",
                     frame_err_count, pkt_count, seq_err_count);
        else n_pass++;
    endtask

    task automatic test_addr_wrap();
        do_reset();
        for (int b = 0; b < PKT; b++)
            send_beat(64'(b), b == 0, b == PKT - 1, (b == 2) ? 4'd3 : 4'd5, 1'b0);
        idle();
        n_checks++;
        if ({addr_err_count, err_sticky, seq_err_count} !== {32'd1, 1'b1, 32'd0})
            $display("FAIL addr_err: got addr=%0d sticky=%b seq=%0d, required 1 1 0",
                     addr_err_count, err_sticky, seq_err_count);
        else n_pass++;
        // Resync near the top of the range, clearing in the same cycle, then cross the wrap.
        send_beat(64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 4'd5, 1'b1);
        send_beat(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'd5, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'd5, 1'b0);
        send_beat(64'h0, 1'b0, 1'b1, 4'd5, 1'b0);
        send_stream(64'd1, 1, 4'd5);
        idle();
        n_checks++;
        if ({seq_err_count, err_sticky, first_err_got} !== {32'd0, 1'b0, 64'd0})
            $display("FAIL wrap_seq: got seq=%0d sticky=%b fg=%h, required 0 0 0",
                     seq_err_count, err_sticky, first_err_got);
        else n_pass++;
        n_checks++;
        if ({beat_count, pkt_count, frame_err_count, addr_err_count} !== {m_beats, m_pkts, m_frame, m_addr})
            $display("FAIL wrap_model: got beats=%0d pkts=%0d frame=%0d addr=%0d, required %0d %0d %0d %0d",
                     beat_count, pkt_count, frame_err_count, addr_err_count, m_beats, m_pkts, m_frame, m_addr);
        else n_pass++;
    endtask

    task automatic test_reset_clear();
        do_reset();
        send_beat(64'd0, 1'b1, 1'b0, 4'd5, 1'b0);
        send_beat(64'd1, 1'b0, 1'b0, 4'd5, 1'b0);
        idle();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.ready, beat_count} !== {1'b0, 32'd0})
            $display("FAIL async_reset: got ready=%b beats=%0d, required 0 0", bus.ready, beat_count);
        else n_pass++;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_stream(64'd0, 2, 4'd5);
        idle();
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, frame_err_count, err_sticky}
            !== {32'd8, 32'd2, 32'd0, 32'd0, 1'b0})
            $display("FAIL restart: got beats=%0d pkts=%0d seq=%0d frame=%0d sticky=%b, required 8 2 0 0 0",
                     beat_count, pkt_count, seq_err_count, frame_err_count, err_sticky);
        else n_pass++;
        clear_stats = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clear_stats = 1'b0;
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky} !== '0)
            $display("FAIL clear: got beats=%0d pkts=%0d seq=%0d frame=%0d addr=%0d sticky=%b, required all 0",
                     beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky);
        else n_pass++;
        send_stream(64'd8, 1, 4'd5);
        idle();
        n_checks++;
        if ({beat_count, pkt_count, seq_err_count, err_sticky} !== {32'd4, 32'd1, 32'd0, 1'b0})
            $display("FAIL after_clear: got beats=%0d pkts=%0d seq=%0d sticky=%b, required 4 1 0 0",
                     beat_count, pkt_count, seq_err_count, err_sticky);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] d, nxt;
        logic        s, e, clr;
        logic [3:0]  a;
        int          pos;
        int unsigned r;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            throttle_en = round[0];
            gap_max = 2;
            nxt = {$urandom, $urandom};
            pos = 0;
            for (int i = 0; i < 80; i++) begin
                d = nxt; s = (pos == 0); e = (pos == PKT - 1); a = my_addr; clr = 1'b0;
                r = $urandom_range(0, 24);
                case (r)
                    0: d = d + 64'd2;
                    1: a = my_addr ^ 4'h3;
                    2: s = ~s;
                    3: e = ~e;
                    4: clr = 1'b1;
                    default: ;
                endcase
                send_beat(d, s, e, a, clr);
                nxt = d + 64'd1;
                pos = (pos + 1) % PKT;
            end
            idle();
            n_checks++;
            if ({beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky}
                !== {m_beats, m_pkts, m_seq, m_frame, m_addr, m_sticky})
                $display("FAIL random_counts[%0d]: got %0d %0d %0d %0d %0d %b, required %0d %0d %0d %0d %0d %b",
                         round, beat_count, pkt_count, seq_err_count, frame_err_count, addr_err_count, err_sticky,
                         m_beats, m_pkts, m_seq, m_frame, m_addr, m_sticky);
            else n_pass++;
            n_checks++;
            if ({first_err_expected, first_err_got} !== {m_fe, m_fg})
                $display("FAIL random_first_err[%0d]: got fe=%h fg=%h, required fe=%h fg=%h",
                         round, first_err_expected, first_err_got, m_fe, m_fg);
            else n_pass++;
        end
        throttle_en = 1'b0;
        gap_max = 0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_backpressure();
        test_seq_gap();
        test_framing();
        test_addr_wrap();
        test_reset_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
